freq_div_prog: RTL

Runtime-programmable clock divider, successor to the fixed-N divider. Divides `clk` by any integer 2..2^W-1 loaded at run time through a valid/ready handshake. Divisor changes take effect only at a period boundary, so the divided output never glitches. Outputs are a divided clock-enable waveform `out` and a one-cycle `tick` per output period; both feed downstream timing and strobe logic.

---
 rtl/freq_div_pkg.sv | 26 ++
 rtl/freq_div_odd50.sv | 31 +++
 rtl/freq_div_prog.sv | 125 ++++++++++++
 3 files changed

// File: rtl/freq_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_div_pkg
// Brief    : Shared constants and divisor clamping for freq_div_prog.
// Revision : 1.0
// ============================================================================
package freq_div_pkg;

   localparam int MIN_DIV   = 2;
   localparam int DIV_W_MAX = 32;

   typedef struct packed {
      logic                 err;
      logic [DIV_W_MAX-1:0] div;
   } clamp_t;

   // Divisors of 0 or 1 cannot form a period, so they are raised to MIN_DIV.
   function automatic clamp_t clamp_div(input logic [DIV_W_MAX-1:0] i_div);
      clamp_t res;
      res.err = (i_div < DIV_W_MAX'(MIN_DIV));
      res.div = res.err ? DIV_W_MAX'(MIN_DIV) : i_div;
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/freq_div_odd50.sv
`default_nettype none
// ============================================================================
// Module   : freq_div_odd50
// Brief    : Falling-edge stage that stretches odd-divisor high time by half a cycle.
// Revision : 1.0
// ============================================================================
module freq_div_odd50
   import freq_div_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_out_r,
   input  logic i_div_odd,
   output logic o_out
);

   logic r_out_n;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         r_out_n <= 1'b0;
      end else begin
         r_out_n <= i_en & i_out_r;
      end
   end

   assign o_out = i_div_odd ? (i_out_r | r_out_n) : i_out_r;

endmodule
`default_nettype wire

// File: rtl/freq_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : freq_div_prog
// Brief    : Runtime-programmable glitch-free clock divider (2..2^W-1).
//            Optional FREQ_DIV_ODD50_EN adds 50% duty for odd divisors.
// Revision : 1.0
// ============================================================================
module freq_div_prog
   import freq_div_pkg::*;
#(
   parameter int W           = 16,
   parameter int DEFAULT_DIV = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic [W-1:0] i_div_in,
   input  logic         i_div_valid,
   output logic         o_div_ready,
   output logic         o_out,
   output logic         o_tick,
   output logic         o_cfg_err
);

   localparam logic [W-1:0] c_ONE     = W'(1);
   localparam logic [W-1:0] c_RST_DIV = W'(DEFAULT_DIV);

   logic [W-1:0] r_div_act;
   logic [W-1:0] r_div_pend;
   logic [W-1:0] r_cnt;
   logic         r_pend;
   logic         r_out;
   logic         r_tick;
   logic         r_cfg_err;

   logic [W-1:0] w_div_act_nx;
   logic [W-1:0] w_cnt_nx;
   logic         w_pend_nx;
   logic         w_tick_nx;
   logic         w_out_nx;
   logic         w_xfer;
   logic         w_wrap;
   clamp_t       w_clamp;

   assign w_xfer  = i_div_valid && !r_pend;
   assign w_wrap  = (r_cnt == r_div_act - c_ONE);
   assign w_clamp = clamp_div(DIV_W_MAX'(i_div_in));

   generate
      if (W < DIV_W_MAX) begin : g_clamp_hi
         logic w_unused_hi;
         assign w_unused_hi = ^w_clamp.div[DIV_W_MAX-1:W];
      end
   endgenerate

   // A request accepted on a wrap edge is not yet in r_pend, so it waits for the next wrap.
   always_comb begin
      w_div_act_nx = r_div_act;
      w_pend_nx    = r_pend;
      w_cnt_nx     = r_cnt;
      w_tick_nx    = 1'b0;
      if (!i_en) begin
         if (r_pend) begin
            w_div_act_nx = r_div_pend;
            w_pend_nx    = 1'b0;
         end
         w_cnt_nx = w_div_act_nx - c_ONE;
      end else if (w_wrap) begin
         w_cnt_nx  = '0;
         w_tick_nx = 1'b1;
         if (r_pend) begin
            w_div_act_nx = r_div_pend;
            w_pend_nx    = 1'b0;
         end
      end else begin
         w_cnt_nx = r_cnt + c_ONE;
      end
      if (w_xfer) begin
         w_pend_nx = 1'b1;
      end
   end

   assign w_out_nx = i_en && (w_cnt_nx < (w_div_act_nx >> 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_act  <= c_RST_DIV;
         r_div_pend <= '0;
         r_cnt      <= c_RST_DIV - c_ONE;
         r_pend     <= 1'b0;
         r_out      <= 1'b0;
         r_tick     <= 1'b0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_div_act <= w_div_act_nx;
         r_cnt     <= w_cnt_nx;
         r_pend    <= w_pend_nx;
         r_out     <= w_out_nx;
         r_tick    <= w_tick_nx;
         if (w_xfer) begin
            r_div_pend <= w_clamp.div[W-1:0];
            r_cfg_err  <= r_cfg_err | w_clamp.err;
         end
      end
   end

   assign o_div_ready = !r_pend;
   assign o_tick      = r_tick;
   assign o_cfg_err   = r_cfg_err;

`ifdef FREQ_DIV_ODD50_EN
   freq_div_odd50 u_odd50 (
      .clk       (clk),
      .rst       (rst),
      .i_en      (i_en),
      .i_out_r   (r_out),
      .i_div_odd (r_div_act[0]),
      .o_out     (o_out)
   );
`else
   assign o_out = r_out;
`endif

endmodule
`default_nettype wire
